rsa_run_ctrl: RTL and testbench

- Run-control sequencer directly downstream of the GPIO synchroniser/edge-detector stage.
- Merges the single-cycle start/stop command pulses from GPIO and from the SPI register file. Issues a launch pulse to the RSA engine and tracks it to completion, abort or timeout.
- Exposes sticky status flags, an elapsed-cycle count and a completion interrupt pulse to the register file.

---
 rtl/rsa_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_rsa_run_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_run_ctrl.sv
// rsa_run_ctrl: run-control sequencer for the RSA engine. It merges the
// GPIO and register-file start/stop pulses and launches one engine run at
// a time. Each run ends in done, abort or timeout.
// Ports: clk, rst (sync, active-high), en (global freeze when low),
//   gpio/reg start/stop command pulses, status_clr, eng_done in;
//   eng_start, eng_abort, irq one-cycle pulses out; running level out;
//   sticky done/aborted/timeout flags and the elapsed RUN-cycle count out.
module rsa_run_ctrl #(
  parameter int unsigned         CNT_W          = 16,
  parameter logic [CNT_W-1:0]    TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             gpio_start_cmd,
  input  logic             gpio_stop_cmd,
  input  logic             reg_start_cmd,
  input  logic             reg_stop_cmd,
  input  logic             status_clr,
  input  logic             eng_done,
  output logic             eng_start,
  output logic             eng_abort,
  output logic             running,
  output logic             done_flag,
  output logic             aborted_flag,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] cycle_count,
  output logic             irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_ABORT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             abt_q, abt_d;
  logic             to_q, to_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;
  logic             irq_q, irq_d;
  logic             run_q, run_d;
  logic             start, stop;

  assign start = gpio_start_cmd | reg_start_cmd;
  assign stop  = gpio_stop_cmd | reg_stop_cmd;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    abt_d   = abt_q;
    to_d    = to_q;
    if (en) begin
      // Clear first so any set event below overrides it.
      if (status_clr) begin
        done_d = 1'b0;
        abt_d  = 1'b0;
        to_d   = 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_d = S_LAUNCH;
            cnt_d   = '0;
            done_d  = 1'b0;
            abt_d   = 1'b0;
            to_d    = 1'b0;
          end
        end
        S_LAUNCH: begin
          state_d = stop ? S_ABORT : S_RUN;
        end
        S_RUN: begin
          // Counter only advances while staying in RUN, so the
          // reported count is the number of full RUN cycles.
          if (eng_done) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (stop) begin
            state_d = S_ABORT;
          end else if (cnt_q == TIMEOUT_CYCLES) begin
            state_d = S_ABORT;
            to_d    = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ABORT: begin
          state_d = S_IDLE;
          abt_d   = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pulses decode the next state; en low forces them off.
  always_comb begin
    start_d = en && (state_d == S_LAUNCH);
    abort_d = en && (state_d == S_ABORT);
    irq_d   = en && (state_d == S_IDLE) &&
              ((state_q == S_RUN) || (state_q == S_ABORT));
    run_d   = (state_d == S_LAUNCH) || (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
      to_q    <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      irq_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
      to_q    <= to_d;
      start_q <= start_d;
      abort_q <= abort_d;
      irq_q   <= irq_d;
      run_q   <= run_d;
    end
  end

  assign eng_start    = start_q;
  assign eng_abort    = abort_q;
  assign irq          = irq_q;
  assign running      = run_q;
  assign done_flag    = done_q;
  assign aborted_flag = abt_q;
  assign timeout_flag = to_q;
  assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_rsa_run_ctrl.sv
// tb_rsa_run_ctrl: scoreboard bench for rsa_run_ctrl.
// Expected pulse events are queued by stimulus and checked by a monitor.
module tb_rsa_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        gpio_start_cmd = 1'b0;
  logic        gpio_stop_cmd = 1'b0;
  logic        reg_start_cmd = 1'b0;
  logic        reg_stop_cmd = 1'b0;
  logic        status_clr = 1'b0;
  logic        eng_done = 1'b0;
  logic        eng_start, eng_abort, running, irq;
  logic        done_flag, aborted_flag, timeout_flag;
  logic [15:0] cycle_count;

  rsa_run_ctrl #(
    .CNT_W(16),
    .TIMEOUT_CYCLES(16'd8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .gpio_start_cmd(gpio_start_cmd),
    .gpio_stop_cmd(gpio_stop_cmd),
    .reg_start_cmd(reg_start_cmd),
    .reg_stop_cmd(reg_stop_cmd),
    .status_clr(status_clr),
    .eng_done(eng_done),
    .eng_start(eng_start),
    .eng_abort(eng_abort),
    .running(running),
    .done_flag(done_flag),
    .aborted_flag(aborted_flag),
    .timeout_flag(timeout_flag),
    .cycle_count(cycle_count),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  kind;
    logic        run;
    logic        d;
    logic        a;
    logic        t;
    logic [15:0] cnt;
  } ev_t;

  localparam logic [2:0] K_START = 3'b100;
  localparam logic [2:0] K_ABORT = 3'b010;
  localparam logic [2:0] K_IRQ   = 3'b001;

  ev_t sbq[$];
  int  n_cmp = 0;
  int  n_fail = 0;

  function automatic ev_t ev(logic [2:0] k, logic r, logic d,
                             logic a, logic t, logic [15:0] c);
    ev_t e;
    e.kind = k;
    e.run  = r;
    e.d    = d;
    e.a    = a;
    e.t    = t;
    e.cnt  = c;
    return e;
  endfunction

  always @(negedge clk) begin
    ev_t act, exp;
    if (eng_start || eng_abort || irq) begin
      act = ev({eng_start, eng_abort, irq}, running, done_flag,
               aborted_flag, timeout_flag, cycle_count);
      n_cmp++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event t=%0t act=%h", $time, act);
      end else begin
        exp = sbq.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL event t=%0t act=%h exp=%h", $time, act, exp);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic go_start();
    sbq.push_back(ev(K_START, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    gpio_start_cmd = 1'b1;
    tick();
    gpio_start_cmd = 1'b0;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick();
    chk("reset_state",
        {eng_start, eng_abort, irq, running, done_flag,
         aborted_flag, timeout_flag, cycle_count}, 32'd0);

    // normal completion: done at cycle 7
    go_start();
    tick(6);
    sbq.push_back(ev(K_IRQ, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5));
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    tick(3);

    // stop mid-run at cycle 4
    sbq.push_back(ev(K_START, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    reg_start_cmd = 1'b1;
    tick();
    reg_start_cmd = 1'b0;
    tick(3);
    sbq.push_back(ev(K_ABORT, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2));
    sbq.push_back(ev(K_IRQ, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2));
    gpio_stop_cmd = 1'b1;
    tick();
    gpio_stop_cmd = 1'b0;
    tick(3);

    // timeout at count 8
    go_start();
    sbq.push_back(ev(K_ABORT, 1'b0, 1'b0, 1'b0, 1'b1, 16'd8));
    sbq.push_back(ev(K_IRQ, 1'b0, 1'b0, 1'b1, 1'b1, 16'd8));
    tick(14);

    // start+stop together in IDLE is ignored
    gpio_start_cmd = 1'b1;
    reg_stop_cmd = 1'b1;
    tick();
    gpio_start_cmd = 1'b0;
    reg_stop_cmd = 1'b0;
    tick(2);
    chk("idle_start_stop",
        {running, done_flag, aborted_flag, timeout_flag, cycle_count},
        {4'b0011, 16'd8});

    // start in RUN ignored; done beats stop
    go_start();
    tick(2);
    reg_start_cmd = 1'b1;
    tick();
    reg_start_cmd = 1'b0;
    sbq.push_back(ev(K_IRQ, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2));
    eng_done = 1'b1;
    gpio_stop_cmd = 1'b1;
    tick();
    eng_done = 1'b0;
    gpio_stop_cmd = 1'b0;
    tick(3);

    // en low for cycles 4..8 with done/stop pulses dropped
    go_start();
    tick(3);
    en = 1'b0;
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    gpio_stop_cmd = 1'b1;
    tick();
    gpio_stop_cmd = 1'b0;
    tick();
    chk("en_freeze", {running, done_flag, aborted_flag, cycle_count},
        {3'b100, 16'd2});
    tick();
    en = 1'b1;
    tick(2);
    sbq.push_back(ev(K_IRQ, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4));
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    tick(3);

    // reset mid-run
    go_start();
    tick(3);
    rst = 1'b1;
    tick();
    chk("reset_mid_run",
        {eng_start, eng_abort, irq, running, done_flag,
         aborted_flag, timeout_flag, cycle_count}, 32'd0);
    rst = 1'b0;
    tick(2);

    // status_clr after completion keeps count
    go_start();
    tick(2);
    sbq.push_back(ev(K_IRQ, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1));
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    tick(2);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    chk("status_clr",
        {done_flag, aborted_flag, timeout_flag, cycle_count},
        {3'b000, 16'd1});

    // status_clr coincident with done: set wins
    go_start();
    tick(2);
    sbq.push_back(ev(K_IRQ, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1));
    eng_done = 1'b1;
    status_clr = 1'b1;
    tick();
    eng_done = 1'b0;
    status_clr = 1'b0;
    tick(2);
    chk("clr_vs_done", {31'd0, done_flag}, 32'd1);

    chk("queue_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
